// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer
//   Frame-rate controller for the intersection scene. Once per video frame
//   (the falling edge of vsync) it advances a six-phase traffic-light FSM and
//   steps the EW car sprite. Everything runs on dclk; all outputs are registered.
//
//   Optional build macro: TLS_SENSOR_EN
//     defined   - NS_GREEN is held (timer saturated at GREEN_FRAMES-1) until an
//                 EW vehicle request has been latched from ew_req.
//     undefined - fixed-time cycle, ew_req is ignored.
//
// Ports
//   dclk        in   pixel clock, rising-edge logic
//   clr_n       in   synchronous active-low reset
//   vsync       in   active-low vsync, same clock domain
//   hold        in   freeze phase timer and car while high
//   ew_req      in   EW vehicle-sensor request (sensor build only)
//   ns_light    out  [1:0] 00 red, 01 yellow, 10 green
//   ew_light    out  [1:0] same encoding
//   phase_timer out  [7:0] frames elapsed in the current phase
//   car_x       out  [9:0] car left edge in active-area pixels
//   frame_tick  out  one-cycle pulse per frame, one cycle after the vsync fall
module traffic_light_sequencer #(
  parameter int GREEN_FRAMES  = 180,
  parameter int YELLOW_FRAMES = 60,
  parameter int ALLRED_FRAMES = 30,
  parameter int CAR_STEP      = 2,
  parameter int CAR_STOP_X    = 130,
  parameter int CAR_END_X     = 640
) (
  input  logic       dclk,
  input  logic       clr_n,
  input  logic       vsync,
  input  logic       hold,
  input  logic       ew_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic [7:0] phase_timer,
  output logic [9:0] car_x,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALLRED_A,
    EW_GREEN,
    EW_YELLOW,
    ALLRED_B
  } state_t;

  localparam logic [7:0]  GREEN_LAST  = 8'(GREEN_FRAMES - 1);
  localparam logic [7:0]  YELLOW_LAST = 8'(YELLOW_FRAMES - 1);
  localparam logic [7:0]  ALLRED_LAST = 8'(ALLRED_FRAMES - 1);
  // Car arithmetic is done one bit wider so the wrap test sees the true sum.
  localparam logic [10:0] STEP_W      = 11'(CAR_STEP);
  localparam logic [10:0] STOP_W      = 11'(CAR_STOP_X);
  localparam logic [10:0] END_W       = 11'(CAR_END_X);
  localparam logic [1:0]  LT_RED      = 2'b00;
  localparam logic [1:0]  LT_YELLOW   = 2'b01;
  localparam logic [1:0]  LT_GREEN    = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic        vsync_q;
  logic        tick;
  logic        advance;
  logic        exit_ok;
  logic        leave;
  logic [7:0]  phase_last;
  logic [7:0]  timer_nxt;
  logic [10:0] car_sum;
  logic [9:0]  car_nxt;
  logic [1:0]  ns_nxt;
  logic [1:0]  ew_nxt;

  // {ns, ew} light pair for a state; only one side is ever non-red.
  function automatic logic [3:0] lights_for(input state_t s);
    case (s)
      NS_GREEN:  lights_for = {LT_GREEN,  LT_RED};
      NS_YELLOW: lights_for = {LT_YELLOW, LT_RED};
      EW_GREEN:  lights_for = {LT_RED,    LT_GREEN};
      EW_YELLOW: lights_for = {LT_RED,    LT_YELLOW};
      default:   lights_for = {LT_RED,    LT_RED};
    endcase
  endfunction

  // The tick is the cycle the first low vsync sample arrives.
  assign tick    = vsync_q & ~vsync;
  assign advance = tick & ~hold;

`ifdef TLS_SENSOR_EN
  logic req_q;

  // A request on the exit tick itself still releases NS_GREEN.
  assign exit_ok = req_q | ew_req;

  // A new request wins over the clear on EW_GREEN entry so it is not lost.
  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      req_q <= 1'b0;
    end else if (ew_req) begin
      req_q <= 1'b1;
    end else if (state_nxt == EW_GREEN && state != EW_GREEN) begin
      req_q <= 1'b0;
    end
  end
`else
  logic unused_ew_req;

  assign exit_ok       = 1'b1;
  assign unused_ew_req = ew_req;
`endif

  always_comb begin
    case (state)
      NS_GREEN, EW_GREEN:   phase_last = GREEN_LAST;
      NS_YELLOW, EW_YELLOW: phase_last = YELLOW_LAST;
      default:              phase_last = ALLRED_LAST;
    endcase
  end

  // Phase timer and next state.
  always_comb begin
    state_nxt = state;
    timer_nxt = phase_timer;
    leave     = 1'b0;
    if (advance) begin
      if (phase_timer >= phase_last) begin
        if (state == NS_GREEN && !exit_ok) begin
          timer_nxt = phase_last;
        end else begin
          leave     = 1'b1;
          timer_nxt = 8'd0;
        end
      end else begin
        timer_nxt = phase_timer + 8'd1;
      end
    end
    if (leave) begin
      case (state)
        NS_GREEN:  state_nxt = NS_YELLOW;
        NS_YELLOW: state_nxt = ALLRED_A;
        ALLRED_A:  state_nxt = EW_GREEN;
        EW_GREEN:  state_nxt = EW_YELLOW;
        EW_YELLOW: state_nxt = ALLRED_B;
        default:   state_nxt = NS_GREEN;
      endcase
    end
  end

  assign {ns_nxt, ew_nxt} = lights_for(state_nxt);

  // Car motion keys off the light the car saw before this tick's update.
  // A car already past the stop line keeps moving on red.
  assign car_sum = {1'b0, car_x} + STEP_W;

  always_comb begin
    car_nxt = car_x;
    if (advance) begin
      if (ew_light != LT_GREEN && {1'b0, car_x} < STOP_W) begin
        car_nxt = (car_sum >= STOP_W) ? STOP_W[9:0] : car_sum[9:0];
      end else if (ew_light != LT_GREEN && {1'b0, car_x} == STOP_W) begin
        car_nxt = car_x;
      end else begin
        car_nxt = (car_sum >= END_W) ? 10'd0 : car_sum[9:0];
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      state       <= ALLRED_B;
      phase_timer <= 8'd0;
      car_x       <= 10'd0;
      ns_light    <= LT_RED;
      ew_light    <= LT_RED;
      frame_tick  <= 1'b0;
      vsync_q     <= 1'b1;
    end else begin
      state       <= state_nxt;
      phase_timer <= timer_nxt;
      car_x       <= car_nxt;
      ns_light    <= ns_nxt;
      ew_light    <= ew_nxt;
      frame_tick  <= tick;
      vsync_q     <= vsync;
    end
  end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
module tb_traffic_light_sequencer;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       vsync = 1'b1;
  logic       hold = 1'b0;
  logic       ew_req = 1'b0;

  logic [1:0] a_ns, a_ew, b_ns, b_ew;
  logic [7:0] a_timer, b_timer;
  logic [9:0] a_car, b_car;
  logic       a_ft, b_ft;

  int total = 0;
  int bad   = 0;

`ifdef TLS_SENSOR_EN
  // Constant request keeps the sensor build on the fixed-time sequence.
  logic req_default = 1'b1;
`else
  logic req_default = 1'b0;
`endif

  // Expected values after tick 1..14 following reset (GREEN=4 YELLOW=2 ALLRED=1).
  logic [1:0] exp_ns [14] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00,
                              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] exp_ew [14] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                              2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
  logic [7:0] exp_tm [14] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd0,
                              8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd0};
  // Car of instance a (STEP=4, STOP=10) after ticks 1..14.
  logic [9:0] exp_car [14] = '{10'd4, 10'd8, 10'd10, 10'd10, 10'd10, 10'd10, 10'd10,
                               10'd10, 10'd14, 10'd18, 10'd22, 10'd26, 10'd30, 10'd34};

  traffic_light_sequencer #(
    .GREEN_FRAMES(4), .YELLOW_FRAMES(2), .ALLRED_FRAMES(1),
    .CAR_STEP(4), .CAR_STOP_X(10), .CAR_END_X(640)
  ) u_a (
    .dclk(clk), .clr_n(clr_n), .vsync(vsync), .hold(hold), .ew_req(ew_req),
    .ns_light(a_ns), .ew_light(a_ew), .phase_timer(a_timer), .car_x(a_car),
    .frame_tick(a_ft)
  );

  traffic_light_sequencer #(
    .GREEN_FRAMES(4), .YELLOW_FRAMES(2), .ALLRED_FRAMES(1),
    .CAR_STEP(2), .CAR_STOP_X(130), .CAR_END_X(640)
  ) u_b (
    .dclk(clk), .clr_n(clr_n), .vsync(vsync), .hold(hold), .ew_req(ew_req),
    .ns_light(b_ns), .ew_light(b_ew), .phase_timer(b_timer), .car_x(b_car),
    .frame_tick(b_ft)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    @(negedge clk);
    clr_n  = 1'b0;
    vsync  = 1'b1;
    hold   = 1'b0;
    ew_req = req_default;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  // One 4-cycle frame; the tick edge is the first rising edge.
  task automatic tick_frame();
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    // Move away from the reset state first so reset has something to clear.
    do_reset();
    repeat (9) tick_frame();
    do_reset();
    total++; if (a_ns !== 2'b00) begin bad++; $display("FAIL reset_ns got=%b want=00", a_ns); end
    total++; if (a_ew !== 2'b00) begin bad++; $display("FAIL reset_ew got=%b want=00", a_ew); end
    total++; if (a_timer !== 8'd0) begin bad++; $display("FAIL reset_timer got=%0d want=0", a_timer); end
    total++; if (a_car !== 10'd0) begin bad++; $display("FAIL reset_car got=%0d want=0", a_car); end
    total++; if (a_ft !== 1'b0) begin bad++; $display("FAIL reset_frame_tick got=%b want=0", a_ft); end
    // ALLRED_B lasts one tick, then NS_GREEN.
    tick_frame();
    total++; if (a_ns !== 2'b10) begin bad++; $display("FAIL reset_first_phase ns got=%b want=10", a_ns); end
  endtask

  task automatic test_sequence();
    do_reset();
    for (int k = 0; k < 28; k++) begin
      tick_frame();
      total++;
      if (a_ns !== exp_ns[k % 14] || a_ew !== exp_ew[k % 14] || a_timer !== exp_tm[k % 14]) begin
        bad++;
        $display("FAIL seq tick=%0d got ns=%b ew=%b t=%0d want ns=%b ew=%b t=%0d",
                 k + 1, a_ns, a_ew, a_timer, exp_ns[k % 14], exp_ew[k % 14], exp_tm[k % 14]);
      end
      total++;
      if (a_ns !== 2'b00 && a_ew !== 2'b00) begin
        bad++;
        $display("FAIL safety tick=%0d got ns=%b ew=%b want one side 00", k + 1, a_ns, a_ew);
      end
      if (k < 14) begin
        total++;
        if (a_car !== exp_car[k]) begin
          bad++;
          $display("FAIL car_seq tick=%0d got=%0d want=%0d", k + 1, a_car, exp_car[k]);
        end
      end
    end
  endtask

  task automatic test_frame_tick();
    int pulses;
    do_reset();
    repeat (2) @(negedge clk);
    total++; if (a_ft !== 1'b0) begin bad++; $display("FAIL ft_idle got=%b want=0", a_ft); end
    vsync = 1'b0;
    @(negedge clk);
    total++; if (a_ft !== 1'b1) begin bad++; $display("FAIL ft_pulse got=%b want=1", a_ft); end
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (a_ft === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL ft_long_low extra_pulses got=%0d want=0", pulses); end
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (a_ft !== 1'b0) begin bad++; $display("FAIL ft_after_rise got=%b want=0", a_ft); end
  endtask

  task automatic test_car_stop();
    do_reset();
    repeat (2) tick_frame();
    total++; if (a_car !== 10'd8) begin bad++; $display("FAIL car_pre_stop got=%0d want=8", a_car); end
    tick_frame();
    total++; if (a_car !== 10'd10) begin bad++; $display("FAIL car_clamp got=%0d want=10", a_car); end
    for (int i = 0; i < 5; i++) begin
      tick_frame();
      total++; if (a_car !== 10'd10) begin bad++; $display("FAIL car_wait tick=%0d got=%0d want=10", i + 4, a_car); end
    end
    total++; if (a_ew !== 2'b10) begin bad++; $display("FAIL car_ew_entry got=%b want=10", a_ew); end
    tick_frame();
    total++; if (a_car !== 10'd14) begin bad++; $display("FAIL car_go got=%0d want=14", a_car); end
  endtask

  task automatic test_hold();
    int pulses;
    do_reset();
    repeat (3) tick_frame();
    total++; if (a_timer !== 8'd2 || a_ns !== 2'b10) begin bad++; $display("FAIL hold_setup got t=%0d ns=%b want t=2 ns=10", a_timer, a_ns); end
    hold = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      vsync = 1'b0;
      @(negedge clk);
      if (a_ft === 1'b1) pulses++;
      vsync = 1'b1;
      repeat (3) @(negedge clk);
    end
    total++; if (pulses !== 5) begin bad++; $display("FAIL hold_pulses got=%0d want=5", pulses); end
    total++; if (a_timer !== 8'd2) begin bad++; $display("FAIL hold_timer got=%0d want=2", a_timer); end
    total++; if (b_car !== 10'd6) begin bad++; $display("FAIL hold_car got=%0d want=6", b_car); end
    total++; if (a_ns !== 2'b10 || a_ew !== 2'b00) begin bad++; $display("FAIL hold_lights got ns=%b ew=%b want 10/00", a_ns, a_ew); end
    hold = 1'b0;
    tick_frame();
    total++; if (a_timer !== 8'd3 || b_car !== 10'd8) begin bad++; $display("FAIL hold_release got t=%0d car=%0d want t=3 car=8", a_timer, b_car); end
    repeat (5) tick_frame();
    total++; if (a_ew !== 2'b10 || a_timer !== 8'd1) begin bad++; $display("FAIL midgreen_setup got ew=%b t=%0d want 10/1", a_ew, a_timer); end
    // Reset in the middle of a frame and phase.
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    total++;
    if (a_ns !== 2'b00 || a_ew !== 2'b00 || a_timer !== 8'd0 || a_car !== 10'd0 || b_car !== 10'd0) begin
      bad++;
      $display("FAIL midreset got ns=%b ew=%b t=%0d car_a=%0d car_b=%0d want 00/00/0/0/0",
               a_ns, a_ew, a_timer, a_car, b_car);
    end
    tick_frame();
    total++; if (a_ns !== 2'b10 || a_timer !== 8'd0) begin bad++; $display("FAIL midreset_allred_b got ns=%b t=%0d want 10/0", a_ns, a_timer); end
  endtask

  task automatic test_wrap();
    logic [9:0] prev_a;
    logic       seen_a, seen_b;
    do_reset();
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int i = 0; i < 2000 && !seen_b; i++) begin
      prev_a = a_car;
      tick_frame();
      if (prev_a == 10'd638) begin
        seen_a = 1'b1;
        total++; if (a_car !== 10'd0) begin bad++; $display("FAIL wrap_a got=%0d want=0", a_car); end
      end
      if (b_car == 10'd638) seen_b = 1'b1;
    end
    total++; if (!seen_a) begin bad++; $display("FAIL wrap_a_timeout got=no_638 want=638_reached"); end
    total++;
    if (!seen_b) begin
      bad++;
      $display("FAIL wrap_b_timeout got=%0d want=638_reached", b_car);
    end else begin
      tick_frame();
      if (b_car !== 10'd0) begin bad++; $display("FAIL wrap_b got=%0d want=0", b_car); end
    end
  endtask

`ifdef TLS_SENSOR_EN
  task automatic test_sensor();
    do_reset();
    ew_req = 1'b0;
    repeat (4) tick_frame();
    for (int i = 0; i < 12; i++) begin
      tick_frame();
      total++;
      if (a_ns !== 2'b10 || a_timer !== 8'd3) begin
        bad++;
        $display("FAIL sensor_wait i=%0d got ns=%b t=%0d want 10/3", i, a_ns, a_timer);
      end
    end
    @(negedge clk);
    ew_req = 1'b1;
    @(negedge clk);
    ew_req = 1'b0;
    tick_frame();
    total++; if (a_ns !== 2'b01 || a_timer !== 8'd0) begin bad++; $display("FAIL sensor_release got ns=%b t=%0d want 01/0", a_ns, a_timer); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_frame_tick();
    test_car_stop();
    test_hold();
    test_wrap();
`ifdef TLS_SENSOR_EN
    test_sensor();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
